// File: rtl/addr_dec_pkg.sv
// Shared constants for addr_decoder_ws: FSM state codes and the default
// window map (internal data RAM plus one slow external window).
package addr_dec_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_4b00;
    localparam logic [31:0] DMEM_LIMIT = 32'h0000_4f00;

    localparam logic [63:0] DEF_BASE  = {32'h0000_4f00, DMEM_BASE};
    localparam logic [63:0] DEF_LIMIT = {32'h0001_0000, DMEM_LIMIT};
    localparam logic [7:0]  DEF_WS    = {4'd3, 4'd0};

endpackage

// File: rtl/region_match.sv
// Combinational window compare: hit when base <= addr < limit.
// An empty or inverted window (limit <= base) never hits.
module region_match (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] limit,
    output logic        hit
);

    assign hit = (limit > base) && (addr >= base) && (addr < limit);

endmodule

// File: rtl/addr_decoder_ws.sv
// Multi-window address decoder with per-region wait states and REQ/READY handshake.
// Optional macro ADDR_DEC_ALIGN_CHECK_EN: misaligned addresses fault like a miss.
module addr_decoder_ws
    import addr_dec_pkg::*;
#(
    parameter int unsigned                 N_REGIONS = 2,
    parameter logic [N_REGIONS*32-1:0]     BASE      = DEF_BASE,
    parameter logic [N_REGIONS*32-1:0]     LIMIT     = DEF_LIMIT,
    parameter logic [N_REGIONS*4-1:0]      WS        = DEF_WS,
    parameter int unsigned                 IDXW      = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ,
    input  logic [31:0]          ADDR,
    output logic [N_REGIONS-1:0] CS_N,
    output logic [IDXW-1:0]      SEL,
    output logic                 BUSY,
    output logic                 READY,
    output logic                 ERR
);

    logic [N_REGIONS-1:0] hits;
    logic [N_REGIONS-1:0] hit_cs_n;
    logic [IDXW-1:0]      hit_idx;
    logic [3:0]           hit_ws;
    logic                 any_hit;
    logic                 fault;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [N_REGIONS-1:0] cs_n_q, cs_n_d;
    logic [IDXW-1:0]      sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;

    for (genvar i = 0; i < N_REGIONS; i++) begin : g_match
        region_match u_match (
            .addr  (ADDR),
            .base  (BASE[32*i +: 32]),
            .limit (LIMIT[32*i +: 32]),
            .hit   (hits[i])
        );
    end

    // Scan from the top down so the lowest-indexed overlapping hit wins.
    always_comb begin
        hit_idx  = '0;
        hit_ws   = '0;
        hit_cs_n = '1;
        any_hit  = 1'b0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx     = IDXW'(i);
                hit_ws      = WS[4*i +: 4];
                hit_cs_n    = '1;
                hit_cs_n[i] = 1'b0;
                any_hit     = 1'b1;
            end
        end
    end

`ifdef ADDR_DEC_ALIGN_CHECK_EN
    assign fault = !any_hit || (ADDR[1:0] != 2'b00);
`else
    assign fault = !any_hit;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    busy_d = 1'b1;
                    if (fault) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cs_n_d = hit_cs_n;
                        sel_d  = hit_idx;
                        cnt_d  = hit_ws;
                        if (hit_ws == 4'd0) begin
                            state_d = DONE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // READY is registered, so it is raised on the edge leaving WAIT.
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cs_n_d  = '1;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                cs_n_d  = '1;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_n_q  <= '1;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign CS_N  = cs_n_q;
    assign SEL   = sel_q;
    assign BUSY  = busy_q;
    assign READY = ready_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Directed bench for addr_decoder_ws with the default two-region map.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_addr_decoder_ws;

    logic        CLK;
    logic        RST;
    logic        REQ;
    logic [31:0] ADDR;
    logic [1:0]  CS_N;
    logic [2:0]  SEL;
    logic        BUSY;
    logic        READY;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    addr_decoder_ws dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .ADDR  (ADDR),
        .CS_N  (CS_N),
        .SEL   (SEL),
        .BUSY  (BUSY),
        .READY (READY),
        .ERR   (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic test_reset();
        logic saw;
        RST  = 1'b1;
        REQ  = 1'b0;
        ADDR = 32'h0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (CS_N !== 2'b11 || SEL !== 3'd0 || BUSY !== 1'b0 || READY !== 1'b0 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init: cs_n=%b sel=%0d busy=%b ready=%b err=%b want 11 0 0 0 0",
                     CS_N, SEL, BUSY, READY, ERR);
        end
        RST = 1'b0;
        @(negedge CLK);
        // Region-1 access, then reset in the middle of its wait states.
        REQ  = 1'b1;
        ADDR = 32'h0000_5000;
        @(negedge CLK);
        REQ = 1'b0;
        n_cmp++;
        if (CS_N !== 2'b01 || BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre: cs_n=%b busy=%b want 01 1", CS_N, BUSY);
        end
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if (CS_N !== 2'b11 || SEL !== 3'd0 || BUSY !== 1'b0 || READY !== 1'b0 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: cs_n=%b sel=%0d busy=%b ready=%b err=%b want 11 0 0 0 0",
                     CS_N, SEL, BUSY, READY, ERR);
        end
        @(negedge CLK);
        RST = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (READY !== 1'b0 || BUSY !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_ready: activity after abort=%b want 0", saw);
        end
    endtask

    task automatic test_region0();
        REQ  = 1'b1;
        ADDR = 32'h0000_4b00;
        @(negedge CLK);
        REQ = 1'b0;
        n_cmp++;
        if (CS_N !== 2'b10 || SEL !== 3'd0 || READY !== 1'b1 || ERR !== 1'b0 || BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL r0_done: cs_n=%b sel=%0d ready=%b err=%b busy=%b want 10 0 1 0 1",
                     CS_N, SEL, READY, ERR, BUSY);
        end
        @(negedge CLK);
        n_cmp++;
        if (CS_N !== 2'b11 || BUSY !== 1'b0 || READY !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_idle: cs_n=%b busy=%b ready=%b want 11 0 0", CS_N, BUSY, READY);
        end
    endtask

    task automatic test_region1();
        REQ  = 1'b1;
        ADDR = 32'h0000_5000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            REQ = 1'b0;
            n_cmp++;
            if (CS_N !== 2'b01 || SEL !== 3'd1 || BUSY !== 1'b1 || ERR !== 1'b0 ||
                READY !== (c == 4)) begin
                n_bad++;
                $display("FAIL r1_cycle%0d: cs_n=%b sel=%0d busy=%b ready=%b err=%b want 01 1 1 %0d 0",
                         c, CS_N, SEL, BUSY, READY, ERR, (c == 4));
            end
            // Retargeting to a miss mid-access must not disturb the latched decode.
            if (c == 2) ADDR = 32'h0000_4afc;
        end
        @(negedge CLK);
        n_cmp++;
        if (CS_N !== 2'b11 || SEL !== 3'd0 || BUSY !== 1'b0 || READY !== 1'b0) begin
            n_bad++;
            $display("FAIL r1_idle: cs_n=%b sel=%0d busy=%b ready=%b want 11 0 0 0",
                     CS_N, SEL, BUSY, READY);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] v_addr [5] = '{32'h0000_4eff, 32'h0000_4f00, 32'h0000_4afc,
                                    32'h0000_ffff, 32'h0001_0000};
        logic [1:0]  v_cs   [5] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b11};
        logic [2:0]  v_sel  [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        logic        v_rdy  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        v_err  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 5; v++) begin
            REQ  = 1'b1;
            ADDR = v_addr[v];
            @(negedge CLK);
            REQ = 1'b0;
            n_cmp++;
            if (CS_N !== v_cs[v] || SEL !== v_sel[v] || READY !== v_rdy[v] || ERR !== v_err[v] ||
                BUSY !== 1'b1) begin
                n_bad++;
                $display("FAIL bound_%h: cs_n=%b sel=%0d ready=%b err=%b busy=%b want %b %0d %b %b 1",
                         v_addr[v], CS_N, SEL, READY, ERR, BUSY, v_cs[v], v_sel[v], v_rdy[v], v_err[v]);
            end
            for (int i = 0; i < 10 && BUSY !== 1'b0; i++) @(negedge CLK);
            n_cmp++;
            if (BUSY !== 1'b0) begin
                n_bad++;
                $display("FAIL bound_drain_%h: busy=%b want 0", v_addr[v], BUSY);
            end
        end
    endtask

    task automatic test_back_to_back();
        REQ  = 1'b1;
        ADDR = 32'h0000_4b00;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b1 || CS_N !== 2'b10 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: ready=%b cs_n=%b err=%b want 1 10 0", READY, CS_N, ERR);
        end
        ADDR = 32'h0000_4afc;
        @(negedge CLK);
        n_cmp++;
        if (READY !== 1'b0 || BUSY !== 1'b0 || CS_N !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_gap: ready=%b busy=%b cs_n=%b want 0 0 11", READY, BUSY, CS_N);
        end
        ADDR = 32'h0000_4b04;
        @(negedge CLK);
        REQ  = 1'b0;
        ADDR = 32'h0000_4afc;
        n_cmp++;
        if (READY !== 1'b1 || CS_N !== 2'b10 || SEL !== 3'd0 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: ready=%b cs_n=%b sel=%0d err=%b want 1 10 0 0",
                     READY, CS_N, SEL, ERR);
        end
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0 || READY !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b ready=%b want 0 0", BUSY, READY);
        end
    endtask

    task automatic test_align();
        REQ  = 1'b1;
        ADDR = 32'h0000_4b02;
        @(negedge CLK);
        REQ = 1'b0;
        n_cmp++;
`ifdef ADDR_DEC_ALIGN_CHECK_EN
        if (CS_N !== 2'b11 || READY !== 1'b1 || ERR !== 1'b1) begin
            n_bad++;
            $display("FAIL align: cs_n=%b ready=%b err=%b want 11 1 1", CS_N, READY, ERR);
        end
`else
        if (CS_N !== 2'b10 || READY !== 1'b1 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL align: cs_n=%b ready=%b err=%b want 10 1 0", CS_N, READY, ERR);
        end
`endif
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_region0();
        test_region1();
        test_boundaries();
        test_back_to_back();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
